// File: rtl/mul_arb_pkg.sv
// ---------------------------------------------------------------------------
// mul_arb_pkg
// Shared definitions for the multiplier-sharing arbiter slice:
//   - default WIDTH / NREQ / MUL_LAT constants
//   - tag_width(): tag field width for a requester count (minimum 1 bit)
//   - TAG_W: tag width for the default requester count
//   - tag_stage_t: one stage of the tag pipe {valid, tag}
// The tag field is sized from DEF_NREQ; raise DEF_NREQ before instantiating
// the top with more requesters than 2**TAG_W.
// ---------------------------------------------------------------------------
package mul_arb_pkg;

    localparam int DEF_WIDTH   = 8;
    localparam int DEF_NREQ    = 4;
    localparam int DEF_MUL_LAT = 2;

    function automatic int tag_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    localparam int TAG_W = tag_width(DEF_NREQ);

    typedef struct packed {
        logic             valid;
        logic [TAG_W-1:0] tag;
    } tag_stage_t;

endpackage

// File: rtl/mul_share_arbiter_rr.sv
// ---------------------------------------------------------------------------
// rr_arbiter
// Combinational one-hot grant among NREQ requesters.
//   MUL_ARB_RR_EN defined  : round-robin; search starts at a pointer register
//                            and wraps; pointer moves past the winner when
//                            'advance' is high.
//   MUL_ARB_RR_EN undefined: fixed priority, lowest index wins; no pointer,
//                            so clk/rst/advance ports are not present.
// Ports:
//   clk, rst (async active-high), advance  -- round-robin build only
//   req [NREQ]  request vector
//   gnt [NREQ]  one-hot-or-zero grant
// ---------------------------------------------------------------------------
module rr_arbiter
    import mul_arb_pkg::*;
#(
    parameter int NREQ = DEF_NREQ
) (
`ifdef MUL_ARB_RR_EN
    input  logic            clk,
    input  logic            rst,
    input  logic            advance,
`endif
    input  logic [NREQ-1:0] req,
    output logic [NREQ-1:0] gnt
);

`ifdef MUL_ARB_RR_EN
    localparam int PTR_W = tag_width(NREQ);

    logic [PTR_W-1:0] ptr_r;
    logic [PTR_W-1:0] ptr_nxt_s;
    logic [NREQ-1:0]  mask_s;
    logic [NREQ-1:0]  pick_s;

    // Requests at or above the pointer win; if none, wrap to the full vector.
    always_comb begin
        mask_s = '0;
        for (int i = 0; i < NREQ; i++) begin
            mask_s[i] = (PTR_W'(i) >= ptr_r);
        end
        pick_s = ((req & mask_s) != '0) ? (req & mask_s) : req;
        // Isolate the lowest set bit of the chosen vector.
        gnt    = pick_s & (~pick_s + {{(NREQ-1){1'b0}}, 1'b1});
    end

    // Next pointer is the index just past the winner, wrapping to 0.
    always_comb begin
        ptr_nxt_s = ptr_r;
        for (int i = 0; i < NREQ; i++) begin
            ptr_nxt_s = gnt[i] ? PTR_W'((i + 1) % NREQ) : ptr_nxt_s;
        end
    end

    // Pointer register; holds when nothing is accepted.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr_r <= '0;
        end else if (advance) begin
            ptr_r <= ptr_nxt_s;
        end else begin
            ptr_r <= ptr_r;
        end
    end
`else
    // Fixed priority: lowest set request bit wins.
    always_comb begin
        gnt = req & (~req + {{(NREQ-1){1'b0}}, 1'b1});
    end
`endif

endmodule

// File: rtl/mul_share_arbiter.sv
// ---------------------------------------------------------------------------
// mul_share_arbiter
// Shares one external fully pipelined unsigned multiplier (latency MUL_LAT
// edges) among NREQ requesters. One requester is granted per cycle, its
// operands are steered onto mul_a/mul_b, and a tag pipe MUL_LAT deep carries
// the requester index so the product returns to the issuer one edge after
// it appears on mul_y. Build macro MUL_ARB_RR_EN selects round-robin
// arbitration; without it arbitration is fixed priority (lowest index).
// Ports:
//   clk, rst          clock, asynchronous active-high reset
//   req_valid[NREQ]   per-requester valid
//   req_a/req_b       packed operands, requester i at [i*WIDTH +: WIDTH]
//   req_ready[NREQ]   combinational one-hot-or-zero grant (0 during reset)
//   mul_a/mul_b       operands to the multiplier (0 when nothing granted)
//   mul_y             product from the multiplier
//   resp_valid[NREQ]  one-cycle response pulse to the issuing requester
//   resp_y            registered product, holds when resp_valid is 0
//   busy              an accepted operation is still awaiting its response
// ---------------------------------------------------------------------------
module mul_share_arbiter
    import mul_arb_pkg::*;
#(
    parameter int WIDTH   = DEF_WIDTH,
    parameter int NREQ    = DEF_NREQ,
    parameter int MUL_LAT = DEF_MUL_LAT
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [NREQ-1:0]       req_valid,
    input  logic [NREQ*WIDTH-1:0] req_a,
    input  logic [NREQ*WIDTH-1:0] req_b,
    output logic [NREQ-1:0]       req_ready,
    output logic [WIDTH-1:0]      mul_a,
    output logic [WIDTH-1:0]      mul_b,
    input  logic [2*WIDTH-1:0]    mul_y,
    output logic [NREQ-1:0]       resp_valid,
    output logic [2*WIDTH-1:0]    resp_y,
    output logic                  busy
);

    logic [NREQ-1:0]    gnt_s;
    logic [NREQ-1:0]    ready_s;
    logic               grant_any_s;
    logic [TAG_W-1:0]   gnt_idx_s;
    logic [WIDTH-1:0]   mul_a_s;
    logic [WIDTH-1:0]   mul_b_s;
    logic [NREQ-1:0]    resp_nxt_s;
    logic               busy_nxt_s;

    tag_stage_t         pipe_r [MUL_LAT];
    logic [NREQ-1:0]    resp_valid_r;
    logic [2*WIDTH-1:0] resp_y_r;
    logic               busy_r;

    rr_arbiter #(
        .NREQ    (NREQ)
    ) u_arb (
`ifdef MUL_ARB_RR_EN
        .clk     (clk),
        .rst     (rst),
        .advance (grant_any_s),
`endif
        .req     (req_valid),
        .gnt     (gnt_s)
    );

    // Grant is suppressed during reset; any grant is an accept since ready
    // only ever follows an asserted valid.
    always_comb begin
        ready_s     = rst ? '0 : gnt_s;
        grant_any_s = |ready_s;
    end

    // Operand steering and grant index encoding (AND-OR mux, zero when idle).
    always_comb begin
        mul_a_s   = '0;
        mul_b_s   = '0;
        gnt_idx_s = '0;
        for (int i = 0; i < NREQ; i++) begin
            mul_a_s   = mul_a_s | (req_a[i*WIDTH +: WIDTH] & {WIDTH{ready_s[i]}});
            mul_b_s   = mul_b_s | (req_b[i*WIDTH +: WIDTH] & {WIDTH{ready_s[i]}});
            gnt_idx_s = ready_s[i] ? TAG_W'(i) : gnt_idx_s;
        end
    end

    // Decode the last tag stage into the next response pulse; busy next cycle
    // is any new accept or any tag still travelling (the last stage becomes
    // the response pulse).
    always_comb begin
        resp_nxt_s = '0;
        busy_nxt_s = grant_any_s;
        for (int i = 0; i < NREQ; i++) begin
            resp_nxt_s[i] = pipe_r[MUL_LAT-1].valid &&
                            (pipe_r[MUL_LAT-1].tag == TAG_W'(i));
        end
        for (int k = 0; k < MUL_LAT; k++) begin
            busy_nxt_s = busy_nxt_s | pipe_r[k].valid;
        end
    end

    // Tag pipe, response register and busy flag; reset discards in-flight tags.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int k = 0; k < MUL_LAT; k++) begin
                pipe_r[k] <= '0;
            end
            resp_valid_r <= '0;
            resp_y_r     <= '0;
            busy_r       <= 1'b0;
        end else begin
            pipe_r[0] <= '{valid: grant_any_s, tag: gnt_idx_s};
            for (int k = 1; k < MUL_LAT; k++) begin
                pipe_r[k] <= pipe_r[k-1];
            end
            resp_valid_r <= resp_nxt_s;
            resp_y_r     <= pipe_r[MUL_LAT-1].valid ? mul_y : resp_y_r;
            busy_r       <= busy_nxt_s;
        end
    end

    assign req_ready  = ready_s;
    assign mul_a      = mul_a_s;
    assign mul_b      = mul_b_s;
    assign resp_valid = resp_valid_r;
    assign resp_y     = resp_y_r;
    assign busy       = busy_r;

endmodule

// File: tb/tb_mul_share_arbiter.sv
// ---------------------------------------------------------------------------
// tb_mul_share_arbiter
// Directed stimulus with hand-computed products. The main process pushes the
// expected {requester, product} whenever it expects an accept; a monitor pops
// and compares on every response pulse. Expected grant order depends on
// whether MUL_ARB_RR_EN is defined for the build.
// ---------------------------------------------------------------------------
module tb_mul_share_arbiter;

    localparam int W = 8;
    localparam int N = 4;
    localparam int L = 2;

    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic [N-1:0]   req_valid;
    logic [N*W-1:0] req_a;
    logic [N*W-1:0] req_b;
    logic [N-1:0]   req_ready;
    logic [W-1:0]   mul_a;
    logic [W-1:0]   mul_b;
    logic [2*W-1:0] mul_y;
    logic [N-1:0]   resp_valid;
    logic [2*W-1:0] resp_y;
    logic           busy;

    logic [W-1:0]   ma_r = '0;
    logic [W-1:0]   mb_r = '0;
    logic [2*W-1:0] my_r = '0;

    int checks = 0;
    int errors = 0;

    typedef struct {
        int idx;
        int y;
    } exp_t;
    exp_t exp_q[$];

`ifdef MUL_ARB_RR_EN
    int all_idx [5] = '{0, 1, 2, 3, 0};
    int all_y   [5] = '{200, 400, 600, 800, 200};
    int wrap_idx[2] = '{3, 0};
    int wrap_y  [2] = '{200, 63};
`else
    int all_idx [5] = '{0, 0, 0, 0, 0};
    int all_y   [5] = '{200, 200, 200, 200, 200};
    int wrap_idx[2] = '{0, 3};
    int wrap_y  [2] = '{63, 200};
`endif

    mul_share_arbiter #(
        .WIDTH   (W),
        .NREQ    (N),
        .MUL_LAT (L)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_a      (req_a),
        .req_b      (req_b),
        .req_ready  (req_ready),
        .mul_a      (mul_a),
        .mul_b      (mul_b),
        .mul_y      (mul_y),
        .resp_valid (resp_valid),
        .resp_y     (resp_y),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    // Two-edge pipelined multiplier, deliberately never reset.
    always @(posedge clk) begin
        ma_r <= mul_a;
        mb_r <= mul_b;
        my_r <= ma_r * mb_r;
    end
    assign mul_y = my_r;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic set_req(input int i, input int a, input int b);
        req_valid[i]     = 1'b1;
        req_a[i*W +: W]  = W'(a);
        req_b[i*W +: W]  = W'(b);
    endtask

    task automatic drain(input int n);
        repeat (n) @(negedge clk);
        chk("queue_drained", exp_q.size(), 0);
    endtask

    // Response monitor: every pulse must match the oldest outstanding issue.
    always @(negedge clk) begin
        exp_t e;
        if (resp_valid != '0) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL resp_unexpected: resp_valid=%b resp_y=%0d, none outstanding", resp_valid, resp_y);
            end else begin
                e = exp_q.pop_front();
                chk("resp_valid", 32'(resp_valid), 32'(1) << e.idx);
                chk("resp_y", 32'(resp_y), e.y);
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        req_valid = '0;
        req_a     = '0;
        req_b     = '0;

        // Reset and idle
        repeat (2) @(negedge clk);
        chk("ready_in_reset", 32'(req_ready), 0);
        @(posedge clk); #1 rst = 1'b0;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            chk("idle_ready", 32'(req_ready), 0);
            chk("idle_mul_a", 32'(mul_a), 0);
            chk("idle_mul_b", 32'(mul_b), 0);
            chk("idle_resp_valid", 32'(resp_valid), 0);
            chk("idle_busy", 32'(busy), 0);
        end

        // Single request on requester 2: 13*11 = 143, latency MUL_LAT+1 edges
        @(posedge clk); #1 set_req(2, 13, 11);
        @(negedge clk);
        chk("single_ready", 32'(req_ready), 32'h4);
        chk("single_mul_a", 32'(mul_a), 13);
        chk("single_mul_b", 32'(mul_b), 11);
        exp_q.push_back('{idx: 2, y: 143});
        @(posedge clk); #1 req_valid = '0;
        @(negedge clk);
        chk("single_busy", 32'(busy), 1);
        chk("single_early_n1", 32'(resp_valid), 0);
        @(negedge clk);
        chk("single_early_n2", 32'(resp_valid), 0);
        @(negedge clk);
        chk("single_pulse", 32'(resp_valid), 32'h4);
        chk("single_y", 32'(resp_y), 143);
        @(negedge clk);
        chk("single_pulse_end", 32'(resp_valid), 0);
        chk("single_busy_end", 32'(busy), 0);
        chk("single_y_hold", 32'(resp_y), 143);

        // Max operands on requester 3: 255*255 = 65025
        @(posedge clk); #1 set_req(3, 255, 255);
        @(negedge clk);
        chk("max_ready", 32'(req_ready), 32'h8);
        exp_q.push_back('{idx: 3, y: 65025});
        @(posedge clk); #1 req_valid = '0;
        drain(4);

        // All four requesters held valid: a = i+1, b = 200
        @(posedge clk); #1;
        for (int i = 0; i < N; i++) set_req(i, i + 1, 200);
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            chk("all_ready", 32'(req_ready), 32'(1) << all_idx[c]);
            if (c > 0) chk("all_busy", 32'(busy), 1);
            exp_q.push_back('{idx: all_idx[c], y: all_y[c]});
            @(posedge clk); #1;
        end
        req_valid = '0;
        drain(5);

        // Requester 2 alone (3*5), then requesters 0 (7*9) and 3 (2*100) together
        @(posedge clk); #1 set_req(2, 3, 5);
        @(negedge clk);
        chk("wrap_pre_ready", 32'(req_ready), 32'h4);
        exp_q.push_back('{idx: 2, y: 15});
        @(posedge clk); #1;
        req_valid = '0;
        set_req(0, 7, 9);
        set_req(3, 2, 100);
        for (int c = 0; c < 2; c++) begin
            @(negedge clk);
            chk("wrap_ready", 32'(req_ready), 32'(1) << wrap_idx[c]);
            exp_q.push_back('{idx: wrap_idx[c], y: wrap_y[c]});
            @(posedge clk); #1;
            req_valid[wrap_idx[c]] = 1'b0;
        end
        req_valid = '0;
        drain(5);

        // Three back-to-back accepts on requester 1, then asynchronous reset
        @(posedge clk); #1 set_req(1, 10, 10);
        @(negedge clk);
        chk("rst_pre_ready", 32'(req_ready), 32'h2);
        repeat (3) @(posedge clk);
        #2 rst = 1'b1;
        #1;
        chk("rst_resp_valid", 32'(resp_valid), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_ready", 32'(req_ready), 0);
        req_valid = '0;
        repeat (2) begin
            @(negedge clk);
            chk("rst_hold_resp_valid", 32'(resp_valid), 0);
            chk("rst_hold_busy", 32'(busy), 0);
        end
        @(posedge clk); #1 rst = 1'b0;
        repeat (3) begin
            @(negedge clk);
            chk("post_rst_quiet", 32'(resp_valid), 0);
        end
        @(posedge clk); #1 set_req(1, 12, 12);
        @(negedge clk);
        chk("post_rst_ready", 32'(req_ready), 32'h2);
        exp_q.push_back('{idx: 1, y: 144});
        @(posedge clk); #1 req_valid = '0;
        drain(5);
        chk("final_busy", 32'(busy), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
